interval_sequencer: RTL and testbench
=====================================

INTERVAL_SEQUENCER -- requirements
Module: interval_sequencer

Interface
REQ-001 Parameter NUM_CNT_BITS, default 4: width of the interval values and of the counter.
REQ-002 Parameter NUM_SLOTS, fixed at 4: number of programmable interval slots.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 n_rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to run the programmed sequence; sampled only in IDLE.
REQ-006 abort  input  1  cancels any sequence in progress.
REQ-007 cfg_we  input  1  slot write strobe.
REQ-008 cfg_addr  input  2  slot index for the write.
REQ-009 cfg_data  input  NUM_CNT_BITS  interval length in cycles for the slot.
REQ-010 num_intervals  input  2  index of the last slot to run; sampled when start is accepted.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 slot_idx  output  2  index of the slot currently being timed.
REQ-013 interval_tick  output  1  one-cycle pulse when a slot's interval completes.
REQ-014 done  output  1  one-cycle pulse when the sequence completes normally.
REQ-015 count_out  output  NUM_CNT_BITS  monitor copy of the internal counter value.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-017 IDLE: when start=1 and abort=0, the block SHALL latch num_intervals, set slot_idx to 0 and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-018 LOAD: the block SHALL assert counter clear for one cycle and drive the counter's rollover_val from the slot at slot_idx.
- If that slot value is nonzero, the next state SHALL be RUN.
- If the slot value is 0, the slot SHALL be skipped with no tick: the block SHALL go to LOAD for the next slot, or to DONE if this is the last slot.
REQ-019 RUN: the block SHALL assert count_enable while rollover_flag=0.
- In the cycle where rollover_flag=1, it SHALL deassert count_enable and pulse interval_tick.
- It SHALL then go to LOAD with slot_idx+1, or to DONE if slot_idx equals the latched num_intervals.
REQ-020 DONE: the block SHALL pulse done for one cycle and return to IDLE.
REQ-021 Latency SHALL be exact. With start high in cycle 0 and a single slot of value N:
- LOAD in cycle 1;
- counting in cycles 2..N+1;
- interval_tick in cycle N+2;
- done in cycle N+3;
- busy high in cycles 1..N+3.
REQ-022 Each additional nonzero slot of value M SHALL add M+2 cycles; each zero slot SHALL add 1 cycle.
REQ-023 abort=1 in LOAD, RUN or DONE SHALL force IDLE on the next edge and clear the counter, with no tick and no done; abort SHALL take priority over start.
REQ-024 abort=1 in the same cycle as a rollover_flag SHALL suppress interval_tick.
REQ-025 start while busy SHALL be ignored.
REQ-026 cfg_we SHALL write cfg_data into slot cfg_addr only in IDLE and SHALL be ignored while busy.
REQ-027 A write and an accepted start in the same cycle SHALL let the start use the pre-write slot value.
REQ-028 Slot value 2^NUM_CNT_BITS-1 SHALL time correctly with no overflow.

Reset
REQ-029 With n_rst=0 at a clock edge:
- state SHALL be IDLE;
- all slots SHALL be 0, and slot_idx and the latched num_intervals SHALL be 0;
- busy, interval_tick and done SHALL be 0;
- the counter SHALL be reset, so count_out=0.
REQ-030 Reset asserted mid-sequence SHALL take effect on that edge with no done pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the constant NUM_SLOTS.
REQ-032 The counter SHALL be one instance of the existing flex_counter sub-module (ports clk, n_rst, clear, count_enable, rollover_val, count_out, rollover_flag), parameterized by NUM_CNT_BITS; the block SHALL NOT contain a second counter.

Verification
REQ-033 Slot0=2, num_intervals=0, start in cycle 0 -> interval_tick in cycle 4, done in cycle 5, busy high in cycles 1-5, count_out=2 in cycle 4.
REQ-034 Slots 3 and 5, num_intervals=1, start in cycle 0 -> ticks in cycles 5 and 12 with slot_idx 0 then 1, done in cycle 13.
REQ-035 Slots 0 and 4, num_intervals=1 -> slot 0 skipped with no tick, single tick in cycle 7, done in cycle 8.
REQ-036 Slot0=7, abort in cycle 5 -> IDLE and busy=0 in cycle 6, no tick, no done, count_out=0 in cycle 7.
REQ-037 cfg_we to slot 0 with value 9 while busy running slot0=3 -> tick timing unchanged; a following run still uses 3.
REQ-038 Slot0=15, start -> tick in cycle 17, done in cycle 18; n_rst low in cycle 10 of a repeat run -> IDLE, all outputs 0, slots reading 0.

Source files
------------

// File: rtl/interval_sequencer_pkg.sv
// interval_sequencer_pkg: shared FSM state type and slot count for the interval sequencer.
package interval_sequencer_pkg;
  localparam int NUM_SLOTS = 4;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: up-counter with clear, enable and a registered flag when the count reaches rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] next_count;
  always_comb
    next_count = clear ? '0
               : !count_enable ? count_out
               : count_out == rollover_val ? NUM_CNT_BITS'(1)
               : count_out + NUM_CNT_BITS'(1);
  always_ff @(posedge clk)
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= !clear && next_count == rollover_val;
    end
endmodule

// File: rtl/interval_sequencer.sv
// interval_sequencer: times a programmed list of up to four intervals, pulsing a tick per interval and done at the end.
module interval_sequencer
  import interval_sequencer_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_addr,
  input  logic [NUM_CNT_BITS-1:0] cfg_data,
  input  logic [1:0]              num_intervals,
  output logic                    busy,
  output logic [1:0]              slot_idx,
  output logic                    interval_tick,
  output logic                    done,
  output logic [NUM_CNT_BITS-1:0] count_out
);
  state_t state, next_state;
  logic [NUM_CNT_BITS-1:0] slots [NUM_SLOTS];
  logic [NUM_CNT_BITS-1:0] run_slots [NUM_SLOTS];
  logic [1:0] last_idx, next_idx;
  logic clear, count_enable, rollover_flag, go, last;
  logic [NUM_CNT_BITS-1:0] cur;
  assign go   = state == IDLE && start && !abort;
  assign last = slot_idx == last_idx;
  assign cur  = run_slots[slot_idx];
  assign busy = state != IDLE;
  // A run works from a snapshot so a same-cycle write cannot leak into it
  always_ff @(posedge clk)
    if (!n_rst) begin
      state     <= IDLE;
      slot_idx  <= '0;
      last_idx  <= '0;
      slots     <= '{default: '0};
      run_slots <= '{default: '0};
    end else begin
      state    <= next_state;
      slot_idx <= next_idx;
      if (go) begin
        last_idx  <= num_intervals;
        run_slots <= slots;
      end
      if (cfg_we && state == IDLE) slots[cfg_addr] <= cfg_data;
    end
  always_comb begin
    next_state    = state;
    next_idx      = slot_idx;
    clear         = 1'b0;
    count_enable  = 1'b0;
    interval_tick = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: if (go) begin
        next_state = LOAD;
        next_idx   = '0;
      end
      LOAD: begin
        clear      = 1'b1;
        next_state = abort ? IDLE : cur != '0 ? RUN : last ? DONE : LOAD;
        if (!abort && cur == '0 && !last) next_idx = slot_idx + 2'd1;
      end
      RUN:
        if (abort) begin
          next_state = IDLE;
          clear      = 1'b1;
        end else if (rollover_flag) begin
          interval_tick = 1'b1;
          next_state    = last ? DONE : LOAD;
          if (!last) next_idx = slot_idx + 2'd1;
        end else count_enable = 1'b1;
      DONE: begin
        next_state = IDLE;
        done       = !abort;
        clear      = abort;
      end
      default: next_state = IDLE;
    endcase
  end
  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (cur),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );
endmodule

// File: tb/tb_interval_sequencer.sv
// tb_interval_sequencer: directed and random runs checked against a timeline model built from slot values.
module tb_interval_sequencer;
  localparam int W = 4;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, abort = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0, num_intervals = '0;
  logic [W-1:0] cfg_data = '0;
  logic busy, interval_tick, done;
  logic [1:0] slot_idx;
  logic [W-1:0] count_out;
  int total = 0, bad = 0;
  int m_slots [4];
  bit active = 1'b0, zero_next = 1'b0;
  int rel = 0, last_rel = 0;
  bit e_tick [96];
  int e_idx [96];
  int e_cnt [96];

  always #5 clk = ~clk;

  interval_sequencer #(.NUM_CNT_BITS(W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .num_intervals(num_intervals),
    .busy(busy), .slot_idx(slot_idx), .interval_tick(interval_tick), .done(done),
    .count_out(count_out)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Relative cycle 1 is the first LOAD; a nonzero slot v costs v+2 cycles, a zero slot 1.
  function automatic void plan(int ni);
    int t = 1;
    for (int r = 0; r < 96; r++) begin
      e_tick[r] = 1'b0;
      e_idx[r]  = 0;
      e_cnt[r]  = -1;
    end
    for (int i = 0; i <= ni; i++) begin
      int v = m_slots[i];
      if (v == 0) t++;
      else begin
        for (int k = 0; k <= v; k++) e_cnt[t + 1 + k] = k;
        e_tick[t + v + 1] = 1'b1;
        e_idx[t + v + 1]  = i;
        t += v + 2;
      end
    end
    last_rel = t;
  endfunction

  task automatic step(bit s, bit a, bit we, int ad, int d, int ni, bit r);
    bit tk;
    start = s; abort = a; cfg_we = we; cfg_addr = ad[1:0];
    cfg_data = d[W-1:0]; num_intervals = ni[1:0]; n_rst = r;
    #1;
    tk = active && e_tick[rel] && !a;
    check("busy", busy, active);
    check("tick", interval_tick, tk);
    check("done", done, active && rel == last_rel && !a);
    if (tk) check("slot_idx", slot_idx, e_idx[rel]);
    if (active && e_cnt[rel] >= 0) check("count", count_out, e_cnt[rel]);
    if (zero_next) check("count_clr", count_out, 0);
    zero_next = 1'b0;
    if (!r) begin
      active = 1'b0;
      zero_next = 1'b1;
      for (int i = 0; i < 4; i++) m_slots[i] = 0;
    end else if (active) begin
      if (a) begin
        active = 1'b0;
        zero_next = 1'b1;
      end else if (rel == last_rel) active = 1'b0;
      else rel++;
    end else begin
      if (s && !a) begin
        plan(ni);
        active = 1'b1;
        rel = 1;
      end
      if (we) m_slots[ad] = d;
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic wr(int ad, int d);
    step(0, 0, 1, ad, d, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_slots[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tick", interval_tick, 0);
    check("rst_done", done, 0);
    check("rst_count", count_out, 0);
    check("rst_idx", slot_idx, 0);
    n_rst = 1'b1;
    wr(0, 2); step(1, 0, 0, 0, 0, 0, 1); idle(7);
    wr(0, 3); wr(1, 5); step(1, 0, 0, 0, 0, 1, 1); idle(15);
    wr(0, 0); wr(1, 4); step(1, 0, 0, 0, 0, 1, 1); idle(10);
    wr(0, 7); step(1, 0, 0, 0, 0, 0, 1); idle(4); step(0, 1, 0, 0, 0, 0, 1); idle(3);
    wr(0, 3); step(1, 0, 0, 0, 0, 0, 1); step(1, 0, 1, 0, 9, 2, 1); idle(5);
    step(1, 0, 1, 0, 9, 0, 1); idle(6);
    step(1, 0, 0, 0, 0, 0, 1); idle(12);
    wr(0, 15); step(1, 0, 0, 0, 0, 0, 1); idle(19);
    step(1, 0, 0, 0, 0, 0, 1); idle(9); step(0, 0, 0, 0, 0, 0, 0);
    check("rst_busy2", busy, 0);
    check("rst_count2", count_out, 0);
    step(1, 0, 0, 0, 0, 3, 1); idle(6);
    step(1, 1, 0, 0, 0, 0, 1); idle(2);
    for (int c = 0; c < 4000; c++) begin
      int d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)), d, int'($urandom_range(0, 3)), $urandom_range(0, 299) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
